inst_prefetch_queue: RTL

Instruction prefetch stage that sits directly upstream of the CPU's fetch/if_id stage. It issues sequential word fetches to an instruction bus with a request/address-ok/data-ok handshake, tracks outstanding requests, and buffers returned words with their PCs in a small FIFO. It presents one instruction per cycle to the decode side with a valid/ready handshake. A flush redirects fetch to a new PC and discards stale in-flight data.

---
 rtl/inst_prefetch_queue.sv | 131 +++++++++++++
 1 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetch with outstanding tracking, PC-tagged FIFO and flush/drain.
// Optional macro INST_PF_BYPASS_EN forwards a bus return straight to decode when the FIFO is empty.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] MAX_L   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {S_START, S_FETCH, S_DRAIN} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, ret_pc_q, ret_pc_d;
    logic [CW-1:0] outst_q, outst_d, discard_q, discard_d, count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [CW:0]   occ;
    logic          acc, ret, live, byp, byp_take, push, pop, fifo_vld;

    // Issue is throttled by FIFO slots already promised to in-flight requests, so the FIFO cannot overflow.
    assign occ        = {1'b0, count_q} + {1'b0, outst_q};
    assign inst_req_o = (state_q == S_FETCH) && (outst_q < MAX_L) && (occ < DEPTH_L);
    assign inst_addr_o = fetch_pc_q;

    assign acc      = inst_req_o & inst_addr_ok_i;
    assign ret      = inst_data_ok_i & (outst_q != '0);
    assign live     = ret & (discard_q == '0) & ~flush_i;
    assign fifo_vld = (count_q != '0);
`ifdef INST_PF_BYPASS_EN
    assign byp      = live & ~fifo_vld;
`else
    assign byp      = 1'b0;
`endif
    assign byp_take = byp & inst_ready_i;
    assign push     = live & ~byp_take;
    assign pop      = fifo_vld & inst_ready_i & ~flush_i;

    assign head         = mem_q[rptr_q];
    assign inst_valid_o = fifo_vld | byp;
    assign inst_o       = byp ? inst_rdata_i : (fifo_vld ? head.inst : 32'h0);
    assign inst_pc_o    = byp ? ret_pc_q     : (fifo_vld ? head.pc   : 32'h0);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ret_pc_d   = ret_pc_q;
        discard_d  = discard_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        outst_d    = outst_q + CW'(acc) - CW'(ret);
        if (flush_i) begin
            // Everything still in flight after this cycle, including a same-cycle accept, is stale.
            fetch_pc_d = new_pc_i;
            ret_pc_d   = new_pc_i;
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            discard_d  = outst_d;
            state_d    = (outst_d != '0) ? S_DRAIN : S_FETCH;
        end else begin
            if (acc)  fetch_pc_d = fetch_pc_q + 32'd4;
            if (live) ret_pc_d   = ret_pc_q + 32'd4;
            if (push) wptr_d     = wptr_q + AW'(1);
            if (pop)  rptr_d     = rptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            case (state_q)
                S_START: state_d = S_FETCH;
                S_DRAIN: begin
                    if (ret) begin
                        discard_d = discard_q - CW'(1);
                        if (discard_q == CW'(1)) state_d = S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_START;
            fetch_pc_q <= RESET_PC;
            ret_pc_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ret_pc_q   <= ret_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wptr_q] <= '{pc: ret_pc_q, inst: inst_rdata_i};
        end
    end
endmodule
